// File: rtl/vx_multi_priority_encoder.sv
// Registered K-grant priority encoder with valid/ready handshake, fixed or round-robin order.
// Optional performance counters are compiled in when VX_MPE_PERF_EN is defined.
module vx_multi_priority_encoder #(
    parameter int N       = 8,
    parameter int K       = 2,
    parameter int REVERSE = 0,
    parameter int ROTATE  = 0,
    parameter int LN      = (N > 1) ? $clog2(N) : 1,
    parameter int CW      = $clog2(K + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [N-1:0]    data_in,
    output logic            ready_in,
    output logic            valid_out,
    output logic [K*N-1:0]  onehot,
    output logic [K*LN-1:0] index,
    output logic [K-1:0]    grant_valid,
    output logic [CW-1:0]   count,
    input  logic            ready_out
`ifdef VX_MPE_PERF_EN
    ,
    output logic [31:0]     perf_stalls,
    output logic [31:0]     perf_empty
`endif
);

    localparam logic [LN-1:0] PTR_RST = (REVERSE != 0) ? LN'(N - 1) : LN'(0);

    logic            valid_q;
    logic [K*N-1:0]  onehot_q, onehot_d;
    logic [K*LN-1:0] index_q, index_d;
    logic [K-1:0]    grant_valid_q, grant_valid_d;
    logic [CW-1:0]   count_q, count_d;
    logic [LN-1:0]   ptr_q, ptr_d;
    logic [LN-1:0]   last_d;
    logic [LN-1:0]   start_s;
    logic [LN-1:0]   pos_s [N];
    logic [N-1:0]    scan_s;
    logic [N-1:0]    used_s;
    logic            hit_s;
    logic            ready_in_s;
    logic            accept_s;

    // Bit position reached by stepping 'step' places from 'base' in the search direction.
    function automatic logic [LN-1:0] wrap_pos(input logic [LN-1:0] base, input int step);
        int p;
        p = (REVERSE != 0) ? int'(base) - step : int'(base) + step;
        p = (p < 0) ? p + N : ((p >= N) ? p - N : p);
        return LN'(p);
    endfunction

    assign ready_in_s = ~valid_q | ready_out;
    assign accept_s   = valid_in & ready_in_s;
    assign start_s    = (ROTATE != 0) ? ptr_q : PTR_RST;

    // Reorder the request bits into search order starting at the start point.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            pos_s[j]  = wrap_pos(start_s, j);
            scan_s[j] = |(data_in & (N'(1'b1) << pos_s[j]));
        end
    end

    // K-stage masked scan: each lane claims the first still-unused request in search order.
    always_comb begin
        onehot_d      = '0;
        index_d       = '0;
        grant_valid_d = '0;
        count_d       = '0;
        last_d        = start_s;
        used_s        = '0;
        hit_s         = 1'b0;
        for (int k = 0; k < K; k++) begin
            for (int j = 0; j < N; j++) begin
                hit_s                  = scan_s[j] & ~used_s[j] & ~grant_valid_d[k];
                used_s[j]              = used_s[j] | hit_s;
                grant_valid_d[k]       = grant_valid_d[k] | hit_s;
                onehot_d[k*N +: N]     = onehot_d[k*N +: N] | (hit_s ? (N'(1'b1) << pos_s[j]) : N'(0));
                index_d[k*LN +: LN]    = hit_s ? pos_s[j] : index_d[k*LN +: LN];
                last_d                 = hit_s ? pos_s[j] : last_d;
            end
        end
        for (int k = 0; k < K; k++) begin
            count_d = count_d + CW'(grant_valid_d[k]);
        end
    end

    // Round-robin pointer advances past the last grant, only on an accepted non-empty vector.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_s && (ROTATE != 0) && (count_d != CW'(0))) begin
            ptr_d = wrap_pos(last_d, 1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Output register stage with backpressure hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q       <= 1'b0;
            onehot_q      <= '0;
            index_q       <= '0;
            grant_valid_q <= '0;
            count_q       <= '0;
            ptr_q         <= PTR_RST;
        end else begin
            ptr_q <= ptr_d;
            if (accept_s) begin
                valid_q       <= 1'b1;
                onehot_q      <= onehot_d;
                index_q       <= index_d;
                grant_valid_q <= grant_valid_d;
                count_q       <= count_d;
            end else if (ready_out) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_q;
            end
        end
    end

`ifdef VX_MPE_PERF_EN
    logic [31:0] perf_stalls_q;
    logic [31:0] perf_empty_q;

    // Stall cycles and accepted all-zero vectors, both free-running and wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stalls_q <= 32'd0;
            perf_empty_q  <= 32'd0;
        end else begin
            perf_stalls_q <= perf_stalls_q + ((valid_q && !ready_out) ? 32'd1 : 32'd0);
            perf_empty_q  <= perf_empty_q + ((accept_s && (data_in == N'(0))) ? 32'd1 : 32'd0);
        end
    end

    assign perf_stalls = perf_stalls_q;
    assign perf_empty  = perf_empty_q;
`endif

    assign ready_in    = ready_in_s;
    assign valid_out   = valid_q;
    assign onehot      = onehot_q;
    assign index       = index_q;
    assign grant_valid = grant_valid_q;
    assign count       = count_q;

endmodule

// File: tb/tb_vx_multi_priority_encoder.sv
// Scoreboard bench for vx_multi_priority_encoder: four configurations share one stimulus stream.
module tb_vx_multi_priority_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_in;
    logic [7:0] data_in;
    logic       ready_out;

    always #5 clk = ~clk;

    logic        ri0, vo0, ri1, vo1, ri2, vo2, ri3, vo3;
    logic [15:0] oh0, oh1, oh2;
    logic [5:0]  ix0, ix1, ix2;
    logic [1:0]  gv0, gv1, gv2, ct0, ct1, ct2;
    logic [0:0]  oh3, ix3, gv3, ct3;
`ifdef VX_MPE_PERF_EN
    logic [31:0] ps0, pe0, ps1, pe1, ps2, pe2, ps3, pe3;
`endif

    vx_multi_priority_encoder #(.N(8), .K(2), .REVERSE(0), .ROTATE(0)) u0 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .ready_in(ri0),
        .valid_out(vo0), .onehot(oh0), .index(ix0), .grant_valid(gv0), .count(ct0), .ready_out(ready_out)
`ifdef VX_MPE_PERF_EN
        , .perf_stalls(ps0), .perf_empty(pe0)
`endif
    );
    vx_multi_priority_encoder #(.N(8), .K(2), .REVERSE(0), .ROTATE(1)) u1 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .ready_in(ri1),
        .valid_out(vo1), .onehot(oh1), .index(ix1), .grant_valid(gv1), .count(ct1), .ready_out(ready_out)
`ifdef VX_MPE_PERF_EN
        , .perf_stalls(ps1), .perf_empty(pe1)
`endif
    );
    vx_multi_priority_encoder #(.N(8), .K(2), .REVERSE(1), .ROTATE(1)) u2 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in), .ready_in(ri2),
        .valid_out(vo2), .onehot(oh2), .index(ix2), .grant_valid(gv2), .count(ct2), .ready_out(ready_out)
`ifdef VX_MPE_PERF_EN
        , .perf_stalls(ps2), .perf_empty(pe2)
`endif
    );
    vx_multi_priority_encoder #(.N(1), .K(1), .REVERSE(0), .ROTATE(0)) u3 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in[0:0]), .ready_in(ri3),
        .valid_out(vo3), .onehot(oh3), .index(ix3), .grant_valid(gv3), .count(ct3), .ready_out(ready_out)
`ifdef VX_MPE_PERF_EN
        , .perf_stalls(ps3), .perf_empty(pe3)
`endif
    );

    logic [31:0] o_oh [4];
    logic [31:0] o_ix [4];
    logic [31:0] o_gv [4];
    logic [31:0] o_ct [4];
    logic        o_v  [4];
    logic        o_ri [4];
    assign o_oh[0] = 32'(oh0); assign o_ix[0] = 32'(ix0); assign o_gv[0] = 32'(gv0); assign o_ct[0] = 32'(ct0);
    assign o_oh[1] = 32'(oh1); assign o_ix[1] = 32'(ix1); assign o_gv[1] = 32'(gv1); assign o_ct[1] = 32'(ct1);
    assign o_oh[2] = 32'(oh2); assign o_ix[2] = 32'(ix2); assign o_gv[2] = 32'(gv2); assign o_ct[2] = 32'(ct2);
    assign o_oh[3] = 32'(oh3); assign o_ix[3] = 32'(ix3); assign o_gv[3] = 32'(gv3); assign o_ct[3] = 32'(ct3);
    assign o_v[0] = vo0; assign o_v[1] = vo1; assign o_v[2] = vo2; assign o_v[3] = vo3;
    assign o_ri[0] = ri0; assign o_ri[1] = ri1; assign o_ri[2] = ri2; assign o_ri[3] = ri3;

    typedef struct packed {
        logic [31:0] oh;
        logic [31:0] ix;
        logic [31:0] gv;
        logic [31:0] ct;
    } exp_t;

    exp_t sb [4][$];
    int   cn   [4] = '{8, 8, 8, 1};
    int   ck   [4] = '{2, 2, 2, 1};
    int   crev [4] = '{0, 0, 1, 0};
    int   crot [4] = '{0, 1, 1, 0};
    int   cln  [4] = '{3, 3, 3, 1};
    int   m_ptr   [4];
    bit   m_valid [4];
    int   m_stalls;
    int   m_empty;
    int   n_checks;
    int   n_errors;

    task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
        end
    endtask

    // Reference: list set bits in search order and hand the first K to lanes 0.. in turn.
    function automatic void model(input int i, input logic [7:0] d, output exp_t e, output int np);
        int p, cnt, last;
        e = '0; cnt = 0; last = 0;
        for (int j = 0; j < cn[i]; j++) begin
            p = (crev[i] != 0) ? (m_ptr[i] - j + cn[i]) % cn[i] : (m_ptr[i] + j) % cn[i];
            if (d[p] && cnt < ck[i]) begin
                e.oh = e.oh | (32'd1 << (cnt * cn[i] + p));
                e.ix = e.ix | (32'(p) << (cnt * cln[i]));
                e.gv = e.gv | (32'd1 << cnt);
                cnt++;
                last = p;
            end
        end
        e.ct = 32'(cnt);
        np = m_ptr[i];
        if (crot[i] != 0 && cnt > 0) np = (crev[i] != 0) ? (last - 1 + cn[i]) % cn[i] : (last + 1) % cn[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            sb[i].delete();
            m_valid[i] = 1'b0;
            m_ptr[i]   = (crev[i] != 0) ? cn[i] - 1 : 0;
        end
        m_stalls = 0;
        m_empty  = 0;
    endtask

    task automatic rst();
        valid_in = 1'b0; data_in = 8'h00; ready_out = 1'b0; reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // One clock: drive, compare every DUT against the scoreboard head, advance the model.
    task automatic cyc(input bit v, input logic [7:0] d, input bit r);
        exp_t e;
        int   np;
        bit   acc;
        valid_in = v; data_in = d; ready_out = r;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("valid_out", i, 32'(o_v[i]), 32'(m_valid[i]));
            check("ready_in", i, 32'(o_ri[i]), 32'(!m_valid[i] || r));
            if (m_valid[i] && sb[i].size() > 0) begin
                check("onehot", i, o_oh[i], sb[i][0].oh);
                check("index", i, o_ix[i], sb[i][0].ix);
                check("grant_valid", i, o_gv[i], sb[i][0].gv);
                check("count", i, o_ct[i], sb[i][0].ct);
            end
        end
        if (m_valid[0] && !r) m_stalls++;
        if (v && (!m_valid[0] || r) && d == 8'h00) m_empty++;
        for (int i = 0; i < 4; i++) begin
            acc = v && (!m_valid[i] || r);
            if (m_valid[i] && r) void'(sb[i].pop_front());
            if (acc) begin
                model(i, d, e, np);
                sb[i].push_back(e);
                m_ptr[i] = np;
            end
            m_valid[i] = acc || (m_valid[i] && !r);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst();
        #1;
        check("rst_ready_in", 0, 32'(ri0), 32'd1);
        check("rst_valid_out", 0, 32'(vo0), 32'd0);
        check("rst_onehot", 0, 32'(oh0), 32'd0);
        check("rst_index", 0, 32'(ix0), 32'd0);
        check("rst_grant_valid", 0, 32'(gv0), 32'd0);
        check("rst_count", 0, 32'(ct0), 32'd0);
`ifdef VX_MPE_PERF_EN
        check("rst_perf_stalls", 0, ps0, 32'd0);
        check("rst_perf_empty", 0, pe0, 32'd0);
`endif

        // Fixed order, forward and reverse
        cyc(1'b1, 8'h2C, 1'b1);
        check("fix_index", 0, 32'(ix0), 32'h1A);
        check("fix_onehot", 0, 32'(oh0), 32'h0804);
        check("fix_gv", 0, 32'(gv0), 32'h3);
        check("fix_count", 0, 32'(ct0), 32'd2);
        check("rev_index", 2, 32'(ix2), 32'h1D);
        check("rev_onehot", 2, 32'(oh2), 32'h0820);

        // Sparse and empty vectors
        cyc(1'b1, 8'h80, 1'b1);
        check("sparse_index", 0, 32'(ix0), 32'h07);
        check("sparse_gv", 0, 32'(gv0), 32'h1);
        check("sparse_count", 0, 32'(ct0), 32'd1);
        cyc(1'b1, 8'h00, 1'b1);
        check("empty_valid", 0, 32'(vo0), 32'd1);
        check("empty_count", 0, 32'(ct0), 32'd0);
        check("empty_onehot", 0, 32'(oh0), 32'd0);

        // Backpressure: three stalled cycles, then transfer and accept together
        repeat (3) cyc(1'b1, 8'h03, 1'b0);
        check("stall_count", 0, 32'(ct0), 32'd0);
        cyc(1'b1, 8'h03, 1'b1);
        check("after_stall_index", 0, 32'(ix0), 32'h08);
        check("after_stall_gv", 0, 32'(gv0), 32'h3);
        cyc(1'b0, 8'h00, 1'b1);

        // Round-robin over a full vector, then a wrapping pick
        rst();
        cyc(1'b1, 8'hFF, 1'b1); check("rr1", 1, 32'(ix1), 32'h08);
        cyc(1'b1, 8'hFF, 1'b1); check("rr2", 1, 32'(ix1), 32'h1A);
        cyc(1'b1, 8'hFF, 1'b1); check("rr3", 1, 32'(ix1), 32'h2C);
        cyc(1'b1, 8'hFF, 1'b1); check("rr4", 1, 32'(ix1), 32'h3E);
        cyc(1'b1, 8'hFF, 1'b1); check("rr5", 1, 32'(ix1), 32'h08);
        cyc(1'b1, 8'h81, 1'b1);
        check("rr_wrap_index", 1, 32'(ix1), 32'h07);
        check("rr_wrap_onehot", 1, 32'(oh1), 32'h0180);
        cyc(1'b1, 8'h03, 1'b1);
        check("rr_ptr1_index", 1, 32'(ix1), 32'h01);
        cyc(1'b0, 8'h00, 1'b1);

        // Reset while a result is pending with the reverse pointer at 4
        rst();
        cyc(1'b1, 8'h60, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        check("pending_valid", 2, 32'(vo2), 32'd1);
        rst();
        #1;
        check("midrst_valid", 2, 32'(vo2), 32'd0);
`ifdef VX_MPE_PERF_EN
        check("midrst_perf_stalls", 0, ps0, 32'd0);
        check("midrst_perf_empty", 0, pe0, 32'd0);
`endif
        cyc(1'b1, 8'hFF, 1'b1);
        check("midrst_ptr_index", 2, 32'(ix2), 32'h37);

        // Random traffic with random backpressure
        for (int t = 0; t < 80; t++) begin
            cyc(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 3) != 0));
        end
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
`ifdef VX_MPE_PERF_EN
        check("perf_stalls", 0, ps0, 32'(m_stalls));
        check("perf_empty", 0, pe0, 32'(m_empty));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
